// File: rtl/registrador_fila.sv
// Show-ahead FIFO of WIDTH-bit words with occupancy count and sticky error flags.
// Buffers player inputs and the round sequence for the game datapath.
module registrador_fila #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             limpa,
    input  logic             escreve,
    input  logic             le,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             vazio,
    output logic             cheio,
    output logic [CW-1:0]    contagem,
    output logic             erro_escrita,
    output logic             erro_leitura
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_w_q, err_w_d;
    logic             err_r_q, err_r_d;
    logic             wr_ok, rd_ok, mem_we;

    always_comb begin
        vazio  = (cnt_q == '0);
        cheio  = (cnt_q == CW'(DEPTH));
        wr_ok  = escreve && (!cheio || le);
        rd_ok  = le && !vazio;
        mem_we = wr_ok && !limpa;

        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        err_w_d = err_w_q || (escreve && cheio && !le);
        err_r_d = err_r_q || (le && vazio);

        if (wr_ok) wptr_d = wptr_q + AW'(1);
        if (rd_ok) rptr_d = rptr_q + AW'(1);
        if (wr_ok && !rd_ok) cnt_d = cnt_q + CW'(1);
        if (rd_ok && !wr_ok) cnt_d = cnt_q - CW'(1);

        if (limpa) begin
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            err_w_d = 1'b0;
            err_r_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            err_w_q <= 1'b0;
            err_r_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            err_w_q <= err_w_d;
            err_r_q <= err_r_d;
        end
    end

    // Storage is left unreset; Q masks it whenever the queue is empty.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[wptr_q] <= D;
    end

    always_comb begin
        Q            = vazio ? '0 : mem_q[rptr_q];
        contagem     = cnt_q;
        erro_escrita = err_w_q;
        erro_leitura = err_r_q;
    end

endmodule

// File: doc/registrador_fila.md
Name: registrador_fila

Overview:
- Parametrised successor of the fixed-width enable/clear register.
- Stores a sequence of WIDTH-bit words in a DEPTH-entry first-in/first-out queue, with a show-ahead output, occupancy count and sticky error flags.
- Used by the game datapath to buffer player inputs and the round sequence between the control unit and the comparison logic.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
CW, $clog2(DEPTH+1), width of the count output (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
clear_n  input  1  asynchronous active-low reset
limpa  input  1  synchronous clear; same effect as reset, taken on the clock edge
escreve  input  1  write request; pushes D this edge
le  input  1  read request; pops the head entry this edge
D  input  WIDTH  write data
Q  output  WIDTH  head entry (show-ahead); 0 when empty
vazio  output  1  queue empty
cheio  output  1  queue full (count == DEPTH)
contagem  output  CW  number of stored entries, 0..DEPTH
erro_escrita  output  1  sticky: write attempted while full without a simultaneous read
erro_leitura  output  1  sticky: read attempted while empty

Behaviour:
- Reset: clock is a single domain. clear_n is asynchronous and active-low.
  - While clear_n=0: write pointer = read pointer = 0, contagem=0, vazio=1, cheio=0, erro_escrita=0, erro_leitura=0, Q=0.
  - Memory contents are not reset; they are unobservable because Q is forced to 0 when empty.
- Synchronous clear: limpa=1 on an edge gives the same state as reset. It has priority over escreve and le in that cycle.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0. Occupancy is held in a separate counter, so full and empty are unambiguous.
- Write accepted when escreve=1 and (cheio=0 or le=1):
  - D is stored at the write pointer.
  - The write pointer increments.
- Read accepted when le=1 and vazio=0:
  - The read pointer increments.
- Count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged when both are accepted.
- Simultaneous escreve and le:
  - Empty: the write is accepted and the read is rejected. erro_leitura sets, count goes 0 -> 1.
  - Full: both are accepted, count stays DEPTH, no error.
  - Otherwise: both are accepted.
- Rejected write (escreve=1, cheio=1, le=0): memory and pointers unchanged; erro_escrita sets.
- Rejected read (le=1, vazio=1): pointers unchanged; erro_leitura sets.
- Error flags stay set until reset or limpa.
- Show-ahead output:
  - Q = mem[read pointer] when vazio=0, else 0.
  - Q is combinational from registered state; no read latency.
- Latency:
  - A word written into an empty queue appears on Q one cycle after the write edge.
  - After a read edge, Q shows the next entry in the same cycle.
- Flag derivation: vazio = (contagem==0), cheio = (contagem==DEPTH). Both are derived from the registered count.
- Reset mid-operation: asserting clear_n=0 at any time empties the queue immediately, without waiting for a clock edge. The first edge after release behaves as from the reset state.

Test Plan:
- Reset, then write 0x1111, 0x2222, 0x3333 on consecutive cycles.
  - Expect contagem=3, vazio=0, Q=0x1111.
  - Three reads give Q=0x2222, 0x3333, then 0 with vazio=1.
- Fill to DEPTH=8 with 0x00A0..0x00A7: cheio=1, contagem=8.
  - A further write of 0xFFFF sets erro_escrita=1 and leaves contagem=8.
  - Draining returns 0x00A0..0x00A7 in order, with no 0xFFFF.
- Full queue, escreve=1 with D=0xBEEF and le=1 in the same cycle:
  - contagem stays 8, no error, Q advances to 0x00A1.
  - 0xBEEF is read last.
- Empty queue, escreve=1 with D=0x0042 and le=1:
  - erro_leitura=1, contagem=1, Q=0x0042 on the next cycle.
- Wrap-around: 20 alternating write/read pairs with incrementing data.
  - Each read returns the matching written value across pointer wrap; contagem never exceeds 1.
- With 5 entries stored and erro_leitura set:
  - limpa=1 for one edge: contagem=0, vazio=1, flags=0, Q=0.
  - Separately, asserting clear_n=0 between edges gives the same result with no clock edge.
